// File: rtl/layer1_pool.sv
// layer1_pool: writes the 64x64 ReLU'd conv result stream into L0 memory and
// computes 2x2 stride-2 max-pooling into L1 memory (32x32).
// Ports:
//   clk, reset (sync, active-low)
//   i_start            - starts a frame (honoured in IDLE/DONE only)
//   i_valid, i_data    - raw-scan conv results, row-major
//   o_l0_we/addr/data  - L0 write, {row,col}, zero-extended pixel
//   o_l1_we/addr/data  - L1 write, {row[5:1],col[5:1]}, pooled max
//   o_go_down          - one-cycle pulse after each non-final row pair
//   o_done             - frame complete, held until next i_start
module layer1_pool #(
  parameter int unsigned IN_W  = 19,
  parameter int unsigned MEM_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  output logic             o_l0_we,
  output logic [11:0]      o_l0_addr,
  output logic [MEM_W-1:0] o_l0_data,
  output logic             o_l1_we,
  output logic [9:0]       o_l1_addr,
  output logic [MEM_W-1:0] o_l1_data,
  output logic             o_go_down,
  output logic             o_done
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned BUF_N = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   row_q;
  logic [CNT_W-1:0]   col_q;
  logic [IN_W-1:0]    h_q;
  logic [IN_W-1:0]    pair_buf [BUF_N];

  logic               l0_we_q;
  logic [11:0]        l0_addr_q;
  logic [MEM_W-1:0]   l0_data_q;
  logic               l1_we_q;
  logic [9:0]         l1_addr_q;
  logic [MEM_W-1:0]   l1_data_q;
  logic               go_down_q;
  logic               done_q;

  logic               active_c;
  logic               buf_we_c;
  logic [IN_W-1:0]    pair_max_c;
  logic [IN_W-1:0]    quad_max_c;
  logic [IN_W-1:0]    buf_rd_c;

  // Horizontal max of the pixel pair, then vertical max against the even row.
  always_comb begin
    active_c   = (state_q == S_EVEN) || (state_q == S_ODD);
    buf_we_c   = active_c && i_valid && (state_q == S_EVEN) && col_q[0];
    buf_rd_c   = pair_buf[col_q[5:1]];
    pair_max_c = (h_q > i_data) ? h_q : i_data;
    quad_max_c = (buf_rd_c > pair_max_c) ? buf_rd_c : pair_max_c;
  end

  // Even-row pair maxima; not reset since every entry is written before read.
  always_ff @(posedge clk) begin
    if (buf_we_c) begin
      pair_buf[col_q[5:1]] <= pair_max_c;
    end
  end

  // Frame FSM, scan counters and registered memory-write outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      h_q       <= '0;
      l0_we_q   <= 1'b0;
      l0_addr_q <= '0;
      l0_data_q <= '0;
      l1_we_q   <= 1'b0;
      l1_addr_q <= '0;
      l1_data_q <= '0;
      go_down_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      l0_we_q   <= 1'b0;
      l1_we_q   <= 1'b0;
      go_down_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            state_q <= S_EVEN;
          end
        end
        S_EVEN, S_ODD: begin
          if (i_valid) begin
            l0_we_q   <= 1'b1;
            l0_addr_q <= {row_q, col_q};
            l0_data_q <= MEM_W'(i_data);
            if (!col_q[0]) begin
              h_q <= i_data;
            end else if (state_q == S_ODD) begin
              l1_we_q   <= 1'b1;
              l1_addr_q <= {row_q[5:1], col_q[5:1]};
              l1_data_q <= MEM_W'(quad_max_c);
            end
            col_q <= col_q + CNT_W'(1);
            if (col_q == CNT_W'(63)) begin
              row_q <= row_q + CNT_W'(1);
              if (state_q == S_EVEN) begin
                state_q <= S_ODD;
              end else if (row_q == CNT_W'(63)) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_EVEN;
                go_down_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_l0_we   = l0_we_q;
  assign o_l0_addr = l0_addr_q;
  assign o_l0_data = l0_data_q;
  assign o_l1_we   = l1_we_q;
  assign o_l1_addr = l1_addr_q;
  assign o_l1_data = l1_data_q;
  assign o_go_down = go_down_q;
  assign o_done    = done_q;

endmodule
